// File: rtl/color_cmd_decoder_pkg.sv
// Shared definitions for the color command decoder: opcodes, nibble addresses,
// FSM states and small helpers.
package color_cmd_decoder_pkg;

  typedef enum logic [1:0] {
    OP_RSVD  = 2'b00,
    OP_WRITE = 2'b01,
    OP_NEXT  = 2'b10,
    OP_RGB   = 2'b11
  } op_e;

  localparam logic [3:0] ADDR_R_HI = 4'd3;
  localparam logic [3:0] ADDR_R_LO = 4'd4;
  localparam logic [3:0] ADDR_G_HI = 4'd5;
  localparam logic [3:0] ADDR_G_LO = 4'd6;
  localparam logic [3:0] ADDR_B_HI = 4'd7;
  localparam logic [3:0] ADDR_B_LO = 4'd8;
  localparam logic [3:0] ADDR_MIN  = ADDR_R_HI;
  localparam logic [3:0] ADDR_MAX  = ADDR_B_LO;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_DATA,
    S_GET_RGB,
    S_ISSUE,
    S_RELEASE,
    S_PULSE
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Nibble k of the {R,G,B} buffer, most significant nibble first.
  function automatic logic [3:0] nibble_at(input logic [23:0] b, input logic [2:0] k);
    case (k)
      3'd0:    return b[23:20];
      3'd1:    return b[19:16];
      3'd2:    return b[15:12];
      3'd3:    return b[11:8];
      3'd4:    return b[7:4];
      default: return b[3:0];
    endcase
  endfunction

endpackage

// File: rtl/color_cmd_decoder_if.sv
// Byte input, regfile write handshake and status signals of the color command decoder.
interface color_cmd_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       ack;
  logic [1:0] channel;
  logic [3:0] address;
  logic [3:0] data;
  logic       valid;
  logic       color_next;
  logic       busy;
  logic       err;

  modport master (
    input  rx_data, rx_valid, ack,
    output channel, address, data, valid, color_next, busy, err
  );

  modport slave (
    output rx_data, rx_valid, ack,
    input  channel, address, data, valid, color_next, busy, err
  );
endinterface

// File: rtl/color_cmd_decoder.sv
// Parses UART command bytes into 4-phase nibble writes and color_next pulses
// for color_regfile. One FSM with a single shared timeout/pulse counter.
module color_cmd_decoder
  import color_cmd_decoder_pkg::*;
#(
  parameter int ACK_TIMEOUT   = 64,
  parameter int FRAME_TIMEOUT = 1000000,
  parameter int NEXT_PULSE    = 4
) (
  input  logic            clk,
  input  logic            rst,
  color_cmd_decoder_if.master bus
);

  localparam int CNT_MAX = max3(ACK_TIMEOUT, FRAME_TIMEOUT, NEXT_PULSE);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e           state_q, state_d;
  logic [23:0]      byte_buf_q, byte_buf_d;
  logic [2:0]       idx_q, idx_d;
  logic             is_write_q, is_write_d;
  logic [1:0]       ch_q, ch_d;
  logic [3:0]       addr_q, addr_d;
  logic [3:0]       data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_clr;

  op_e  op;
  logic rsvd_ok;
  logic frame_exp, ack_exp, pulse_done;

  assign op         = op_e'(bus.rx_data[7:6]);
  assign rsvd_ok    = (bus.rx_data[5:2] == 4'h0);
  assign frame_exp  = (cnt_q == CNT_W'(FRAME_TIMEOUT - 1));
  assign ack_exp    = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
  assign pulse_done = (cnt_q == CNT_W'(NEXT_PULSE - 1));

  // NOTE: every signal gets its default before the case; a path that leaves one
  // unassigned would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    byte_buf_d = byte_buf_q;
    idx_d      = idx_q;
    is_write_d = is_write_q;
    ch_d       = ch_q;
    addr_d     = addr_q;
    data_d     = data_q;
    err_d      = 1'b0;
    cnt_clr    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid) begin
          case (op)
            OP_WRITE: begin
              ch_d            = bus.rx_data[5:4];
              byte_buf_d[3:0] = bus.rx_data[3:0];
              is_write_d      = 1'b1;
              state_d         = S_GET_DATA;
            end
            OP_NEXT: begin
              if (rsvd_ok) begin
                ch_d    = bus.rx_data[1:0];
                state_d = S_PULSE;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_RGB: begin
              if (rsvd_ok) begin
                ch_d       = bus.rx_data[1:0];
                idx_d      = 3'd0;
                is_write_d = 1'b0;
                state_d    = S_GET_RGB;
              end else begin
                err_d = 1'b1;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      // Address is validated together with the data byte so a bad WRITE costs one err.
      S_GET_DATA: begin
        if (bus.rx_valid) begin
          if (bus.rx_data[7:4] == 4'h0 && byte_buf_q[3:0] >= ADDR_MIN &&
              byte_buf_q[3:0] <= ADDR_MAX) begin
            addr_d  = byte_buf_q[3:0];
            data_d  = bus.rx_data[3:0];
            state_d = S_ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (frame_exp) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_GET_RGB: begin
        if (bus.rx_valid) begin
          byte_buf_d = {byte_buf_q[15:0], bus.rx_data};
          cnt_clr    = 1'b1;
          if (idx_q == 3'd2) begin
            idx_d   = 3'd0;
            addr_d  = ADDR_MIN;
            data_d  = byte_buf_d[23:20];
            state_d = S_ISSUE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else if (frame_exp) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        if (bus.rx_valid) err_d = 1'b1;
        if (bus.ack) begin
          state_d = S_RELEASE;
        end else if (ack_exp) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_RELEASE: begin
        if (bus.rx_valid) err_d = 1'b1;
        if (!bus.ack) begin
          if (is_write_q || idx_q == 3'd5) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            addr_d  = ADDR_MIN + 4'(idx_q) + 4'd1;
            data_d  = nibble_at(byte_buf_q, idx_q + 3'd1);
            state_d = S_ISSUE;
          end
        end else if (ack_exp) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_PULSE: begin
        if (bus.rx_valid) err_d = 1'b1;
        if (pulse_done) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_buf_q <= '0;
      idx_q      <= '0;
      is_write_q <= 1'b0;
      ch_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_buf_q <= byte_buf_d;
      idx_q      <= idx_d;
      is_write_q <= is_write_d;
      ch_q       <= ch_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      err_q      <= err_d;
      // Reload on every state entry and on each RGB byte; saturate otherwise.
      if (cnt_clr || state_d != state_q) cnt_q <= '0;
      else if (cnt_q != CNT_W'(CNT_MAX)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.channel    = ch_q;
  assign bus.address    = addr_q;
  assign bus.data       = data_q;
  assign bus.valid      = (state_q == S_ISSUE);
  assign bus.color_next = (state_q == S_PULSE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.err        = err_q;

endmodule

// File: tb/tb_color_cmd_decoder.sv
// Self-checking bench for color_cmd_decoder: directed vector table, hand-written
// corner sequences, and randomized commands against a frame-level reference model.
module tb_color_cmd_decoder;

  localparam int ACK_TO   = 64;
  localparam int FRAME_TO = 50;
  localparam int PULSE_W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  color_cmd_decoder_if bus();

  color_cmd_decoder #(
    .ACK_TIMEOUT  (ACK_TO),
    .FRAME_TIMEOUT(FRAME_TO),
    .NEXT_PULSE   (PULSE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Regfile model: ack two cycles into valid, drop ack once valid is seen low.
  bit ack_en = 1'b1;
  int hi_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      bus.ack = 1'b0;
      hi_cnt  = 0;
    end else if (bus.valid === 1'b1) begin
      hi_cnt++;
      if (ack_en && hi_cnt >= 2) bus.ack = 1'b1;
    end else begin
      hi_cnt  = 0;
      bus.ack = 1'b0;
    end
  end

  // Monitor: log each request, count err/color_next cycles, check hold stability.
  int         wr_cnt = 0, err_cnt = 0, next_cyc = 0, vrun = 0, last_vrun = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_ad = 8'h00;
  logic [9:0] wr_q [$];
  always @(negedge clk) begin
    if (bus.valid === 1'b1 && prev_valid)
      check("addr_data_stable", 32'({bus.address, bus.data}), 32'(prev_ad));
    if (bus.valid === 1'b1 && !prev_valid) begin
      wr_cnt++;
      wr_q.push_back({bus.channel, bus.address, bus.data});
    end
    if (bus.valid === 1'b1) vrun++;
    else if (prev_valid) begin
      last_vrun = vrun;
      vrun      = 0;
    end
    if (bus.err === 1'b1) err_cnt++;
    if (bus.color_next === 1'b1) next_cyc++;
    prev_valid = (bus.valid === 1'b1);
    prev_ad    = {bus.address, bus.data};
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] b [4], input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      send_byte(b[i]);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (bus.busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("busy_low_after_frame", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Reference model: expected writes/errs/pulse cycles straight from the opcode rules.
  logic [9:0] exp_q [$];
  int         exp_err, exp_ncyc;
  logic [1:0] exp_ch;

  task automatic model_frame(input logic [7:0] b [4], input int n);
    logic [1:0] op;
    logic [5:0] f;
    logic [7:0] byt;
    op = b[0][7:6];
    f  = b[0][5:0];
    if (op == 2'b01) begin
      exp_ch = f[5:4];
      if (n == 2 && b[1] < 16 && f[3:0] >= 3 && f[3:0] <= 8)
        exp_q.push_back({f[5:4], f[3:0], b[1][3:0]});
      else
        exp_err++;
    end else if (op == 2'b10 && f[5:2] == 0) begin
      exp_ch = f[1:0];
      exp_ncyc += PULSE_W;
    end else if (op == 2'b11 && f[5:2] == 0) begin
      exp_ch = f[1:0];
      for (int i = 0; i < 6; i++) begin
        byt = b[1 + i / 2];
        exp_q.push_back({f[1:0], 4'(3 + i), (i % 2 == 0) ? byt[7:4] : byt[3:0]});
      end
    end else begin
      exp_err++;
    end
  endtask

  task automatic gen_cmd(output logic [7:0] b [4], output int n);
    int         kind;
    logic [7:0] r;
    kind = $urandom_range(0, 4);
    r    = 8'($urandom);
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    case (kind)
      0: begin
        b[0] = {2'b01, 2'($urandom), 4'($urandom_range(3, 8))};
        b[1] = 8'($urandom_range(0, 15));
        n    = 2;
      end
      1: begin
        b[0] = {2'b01, r[5:0]};
        n    = 2;
      end
      2: begin
        b[0] = {6'b110000, 2'($urandom)};
        n    = 4;
      end
      3: begin
        b[0] = {6'b100000, 2'($urandom)};
        n    = 1;
      end
      default: begin
        if (r[7:6] == 2'b01) r[7:6] = 2'b00;
        if (r[7:6] != 2'b00 && r[5:2] == 4'h0) r[5] = 1'b1;
        b[0] = r;
        n    = 1;
      end
    endcase
  endtask

  typedef struct {
    int         n;
    logic [7:0] b [4];
    int         nwr;
    int         nerr;
    int         ncyc;
    logic [1:0] ch;
    logic [3:0] la;
    logic [3:0] ld;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         w0, e0, c0, k;
    logic [7:0] fb [4];
    int         fn;

    vecs[0]  = '{2, '{8'h53, 8'h0A, 8'h00, 8'h00}, 1, 0, 0, 2'd1, 4'd3, 4'hA};
    vecs[1]  = '{4, '{8'hC2, 8'h12, 8'h34, 8'h56}, 6, 0, 0, 2'd2, 4'd8, 4'h6};
    vecs[2]  = '{1, '{8'h83, 8'h00, 8'h00, 8'h00}, 0, 0, 4, 2'd3, 4'd0, 4'h0};
    vecs[3]  = '{2, '{8'h4F, 8'h01, 8'h00, 8'h00}, 0, 1, 0, 2'd0, 4'd0, 4'h0};
    vecs[4]  = '{2, '{8'h45, 8'h17, 8'h00, 8'h00}, 0, 1, 0, 2'd0, 4'd0, 4'h0};
    vecs[5]  = '{1, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, 1, 0, 2'd0, 4'd0, 4'h0};
    vecs[6]  = '{1, '{8'h84, 8'h00, 8'h00, 8'h00}, 0, 1, 0, 2'd0, 4'd0, 4'h0};
    vecs[7]  = '{2, '{8'h67, 8'h0F, 8'h00, 8'h00}, 1, 0, 0, 2'd2, 4'd7, 4'hF};
    vecs[8]  = '{1, '{8'hFF, 8'h00, 8'h00, 8'h00}, 0, 1, 0, 2'd2, 4'd0, 4'h0};
    vecs[9]  = '{2, '{8'h48, 8'h00, 8'h00, 8'h00}, 1, 0, 0, 2'd0, 4'd8, 4'h0};
    vecs[10] = '{2, '{8'h42, 8'h05, 8'h00, 8'h00}, 0, 1, 0, 2'd0, 4'd0, 4'h0};

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(bus.valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_color_next", 32'(bus.color_next), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    check("reset_chan_addr_data", 32'({bus.channel, bus.address, bus.data}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed vector table.
    foreach (vecs[i]) begin
      w0 = wr_cnt; e0 = err_cnt; c0 = next_cyc;
      wr_q.delete();
      send_frame(vecs[i].b, vecs[i].n, 1);
      wait_idle(300);
      check($sformatf("v%0d_writes", i), 32'(wr_cnt - w0), 32'(vecs[i].nwr));
      check($sformatf("v%0d_errs", i), 32'(err_cnt - e0), 32'(vecs[i].nerr));
      check($sformatf("v%0d_next_cycles", i), 32'(next_cyc - c0), 32'(vecs[i].ncyc));
      check($sformatf("v%0d_channel", i), 32'(bus.channel), 32'(vecs[i].ch));
      if (vecs[i].nwr > 0 && wr_q.size() > 0)
        check($sformatf("v%0d_last_addr_data", i), 32'(wr_q[$][7:0]),
              32'({vecs[i].la, vecs[i].ld}));
    end

    // RGB burst ordering.
    wr_q.delete();
    fb = '{8'hC2, 8'h12, 8'h34, 8'h56};
    send_frame(fb, 4, 1);
    wait_idle(300);
    check("rgb_order_count", 32'(wr_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < wr_q.size(); i++)
      check($sformatf("rgb_order_%0d", i), 32'(wr_q[i]), 32'({2'd2, 4'(3 + i), 4'(1 + i)}));

    // Ack never arrives: valid held exactly ACK_TO cycles, then err and IDLE.
    ack_en = 1'b0;
    w0 = wr_cnt; e0 = err_cnt;
    fb = '{8'h44, 8'h07, 8'h00, 8'h00};
    send_frame(fb, 2, 1);
    wait_idle(300);
    check("ack_timeout_requests", 32'(wr_cnt - w0), 32'd1);
    check("ack_timeout_valid_cycles", 32'(last_vrun), 32'(ACK_TO));
    check("ack_timeout_err", 32'(err_cnt - e0), 32'd1);
    ack_en = 1'b1;

    // Byte arriving mid-burst is dropped with err; burst completes untouched.
    wr_q.delete();
    w0 = wr_cnt; e0 = err_cnt;
    fb = '{8'hC0, 8'hAB, 8'hCD, 8'hEF};
    send_frame(fb, 4, 1);
    k = 0;
    while (bus.valid !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("overrun_saw_valid", 32'(bus.valid), 32'd1);
    send_byte(8'h53);
    wait_idle(300);
    check("overrun_writes", 32'(wr_cnt - w0), 32'd6);
    check("overrun_err", 32'(err_cnt - e0), 32'd1);
    check("overrun_channel_kept", 32'(bus.channel), 32'd0);
    for (int i = 0; i < 6 && i < wr_q.size(); i++)
      check($sformatf("overrun_nibble_%0d", i), 32'(wr_q[i]), 32'({2'd0, 4'(3 + i), 4'(10 + i)}));

    // Frame stalls mid-RGB: err after FRAME_TO idle cycles, nothing written.
    w0 = wr_cnt; e0 = err_cnt;
    fb = '{8'hC1, 8'h11, 8'h00, 8'h00};
    send_frame(fb, 2, 1);
    wait_idle(200);
    check("frame_timeout_err", 32'(err_cnt - e0), 32'd1);
    check("frame_timeout_writes", 32'(wr_cnt - w0), 32'd0);

    // Reset during the third RGB nibble, then a normal WRITE.
    w0 = wr_cnt;
    fb = '{8'hC1, 8'h9A, 8'hBC, 8'hDE};
    send_frame(fb, 4, 1);
    k = 0;
    while (wr_cnt < w0 + 3 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("mid_burst_third_request", 32'(wr_cnt - w0), 32'd3);
    rst = 1'b1;
    #1;
    check("mid_reset_outputs",
          32'({bus.valid, bus.busy, bus.color_next, bus.err, bus.channel, bus.address, bus.data}),
          32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    wr_q.delete();
    w0 = wr_cnt; e0 = err_cnt;
    fb = '{8'h65, 8'h09, 8'h00, 8'h00};
    send_frame(fb, 2, 1);
    wait_idle(300);
    check("post_reset_writes", 32'(wr_cnt - w0), 32'd1);
    check("post_reset_errs", 32'(err_cnt - e0), 32'd0);
    if (wr_q.size() > 0) check("post_reset_write", 32'(wr_q[0]), 32'({2'd2, 4'd5, 4'd9}));

    // Randomized commands against the reference model.
    wr_q.delete();
    exp_q.delete();
    exp_err  = 0;
    exp_ncyc = 0;
    exp_ch   = 2'd2;
    e0 = err_cnt; c0 = next_cyc;
    for (int c = 0; c < 40; c++) begin
      gen_cmd(fb, fn);
      model_frame(fb, fn);
      send_frame(fb, fn, $urandom_range(1, 3));
      wait_idle(300);
    end
    check("rand_write_count", 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check($sformatf("rand_write_%0d", i), 32'(wr_q[i]), 32'(exp_q[i]));
    check("rand_errs", 32'(err_cnt - e0), 32'(exp_err));
    check("rand_next_cycles", 32'(next_cyc - c0), 32'(exp_ncyc));
    check("rand_channel", 32'(bus.channel), 32'(exp_ch));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
